// File: rtl/ppu_vram.sv
// ppu_vram: PPU video-memory responder.
// Serves the renderer's fetch port every cycle. When the renderer releases
// the bus, it runs a single buffered CPU access. Owns the mirrored 2 KiB
// nametable RAM and the aliased palette RAM. Pattern-table accesses are
// forwarded to the external CHR ROM.
module ppu_vram #(
  parameter int NT_AW  = 11,
  parameter int PAL_AW = 5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        render_active_in,
  input  logic        mirror_v_in,
  input  logic [13:0] rd_a_in,
  output logic [7:0]  rd_d_out,
  input  logic        ri_req_in,
  input  logic        ri_we_in,
  input  logic [13:0] ri_a_in,
  input  logic [7:0]  ri_d_in,
  output logic [7:0]  ri_d_out,
  output logic        ri_rd_vld_out,
  output logic        ri_busy_out,
  output logic        ri_ovf_out,
  output logic [12:0] chr_a_out,
  input  logic [7:0]  chr_d_in
);

  localparam int NT_DEPTH  = 1 << NT_AW;
  localparam int PAL_DEPTH = 1 << PAL_AW;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  // Nametable index: bit 10 selects the physical page under vertical
  // mirroring, bit 11 under horizontal; the 0x3000 range folds onto 0x2000.
  function automatic logic [NT_AW-1:0] nt_index(input logic [NT_AW:0] a,
                                                input logic mv);
    return {(mv ? a[NT_AW-1] : a[NT_AW]), a[NT_AW-2:0]};
  endfunction

  // Palette index: sprite entries 0x10/0x14/0x18/0x1C share storage with
  // background entries 0x00/0x04/0x08/0x0C.
  function automatic logic [PAL_AW-1:0] pal_index(input logic [PAL_AW-1:0] a);
    if (a[PAL_AW-1] && (a[1:0] == 2'b00))
      return {1'b0, a[PAL_AW-2:0]};
    return a;
  endfunction

  logic [7:0]        nt_ram  [NT_DEPTH];
  logic [5:0]        pal_ram [PAL_DEPTH];

  buf_state_t        state_q;
  buf_state_t        state_d;

  logic              pend_we_p0;
  logic [13:0]       pend_a_p0;
  logic [7:0]        pend_d_p0;

  logic              cpu_slot;
  logic              buf_load;
  logic              req_drop;

  logic [13:0]       port_a;
  logic              is_pal;
  logic              is_nt;
  logic [NT_AW-1:0]  nt_idx;
  logic [PAL_AW-1:0] pal_idx;
  logic [7:0]        port_rdata;

  // Pending-buffer state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      state_q <= BUF_EMPTY;
    else
      state_q <= state_d;
  end

  // Pending-buffer next state: a slot frees the entry at the same edge a new request may refill it
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY: if (ri_req_in) state_d = BUF_FULL;
      BUF_FULL:  if (cpu_slot)  state_d = ri_req_in ? BUF_FULL : BUF_EMPTY;
      default:   state_d = BUF_EMPTY;
    endcase
  end

  // Arbiter outputs: renderer has absolute priority, CPU slot only on idle render cycles
  always_comb begin
    ri_busy_out = (state_q == BUF_FULL);
    cpu_slot    = (state_q == BUF_FULL) && !render_active_in;
    buf_load    = ri_req_in && ((state_q == BUF_EMPTY) || cpu_slot);
    req_drop    = ri_req_in && (state_q == BUF_FULL) && !cpu_slot;
  end

  // Stage p0: capture the CPU request into the single-entry buffer
  always_ff @(posedge clk_in) begin
    if (buf_load) begin
      pend_we_p0 <= ri_we_in;
      pend_a_p0  <= ri_a_in;
      pend_d_p0  <= ri_d_in;
    end
  end

  // Shared port address and region decode
  always_comb begin
    port_a    = cpu_slot ? pend_a_p0 : rd_a_in;
    chr_a_out = port_a[12:0];
    is_pal    = (port_a[13:8] == 6'h3F);
    is_nt     = port_a[13] && !is_pal;
    nt_idx    = nt_index(port_a[NT_AW:0], mirror_v_in);
    pal_idx   = pal_index(port_a[PAL_AW-1:0]);
  end

  // Port read data mux: CHR by default, RAMs by region
  always_comb begin
    port_rdata = chr_d_in;
    if (is_pal)
      port_rdata = {2'b00, pal_ram[pal_idx]};
    else if (is_nt)
      port_rdata = nt_ram[nt_idx];
  end

  // CPU writes commit at the end of their slot; CHR writes are ignored
  always_ff @(posedge clk_in) begin
    if (cpu_slot && pend_we_p0) begin
      if (is_nt)
        nt_ram[nt_idx] <= pend_d_p0;
      else if (is_pal)
        pal_ram[pal_idx] <= pend_d_p0[5:0];
    end
  end

  // Stage p1: renderer data register, held while the CPU owns the port
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      rd_d_out <= 8'h00;
    else if (!cpu_slot)
      rd_d_out <= port_rdata;
  end

  // Stage p1: CPU read data with its one-cycle valid
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ri_d_out      <= 8'h00;
      ri_rd_vld_out <= 1'b0;
    end else begin
      ri_rd_vld_out <= cpu_slot && !pend_we_p0;
      if (cpu_slot && !pend_we_p0)
        ri_d_out <= port_rdata;
    end
  end

  // Sticky overflow: set whenever a request finds the buffer occupied
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      ri_ovf_out <= 1'b0;
    else if (req_drop)
      ri_ovf_out <= 1'b1;
  end

endmodule

// File: tb/tb_ppu_vram.sv
// tb_ppu_vram: directed stimulus with a scoreboard; CPU read results and
// renderer read results are queued at issue time and popped by a monitor.
module tb_ppu_vram;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        render_active_in = 1'b0;
  logic        mirror_v_in = 1'b0;
  logic [13:0] rd_a_in = 14'h0;
  logic [7:0]  rd_d_out;
  logic        ri_req_in = 1'b0;
  logic        ri_we_in = 1'b0;
  logic [13:0] ri_a_in = 14'h0;
  logic [7:0]  ri_d_in = 8'h0;
  logic [7:0]  ri_d_out;
  logic        ri_rd_vld_out;
  logic        ri_busy_out;
  logic        ri_ovf_out;
  logic [12:0] chr_a_out;
  logic [7:0]  chr_d_in = 8'h0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] cq[$];
  logic [7:0] rq[$];
  logic       rd_issue = 1'b0;
  logic       rd_pend  = 1'b0;

  ppu_vram #(.NT_AW(11), .PAL_AW(5)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .render_active_in (render_active_in),
    .mirror_v_in      (mirror_v_in),
    .rd_a_in          (rd_a_in),
    .rd_d_out         (rd_d_out),
    .ri_req_in        (ri_req_in),
    .ri_we_in         (ri_we_in),
    .ri_a_in          (ri_a_in),
    .ri_d_in          (ri_d_in),
    .ri_d_out         (ri_d_out),
    .ri_rd_vld_out    (ri_rd_vld_out),
    .ri_busy_out      (ri_busy_out),
    .ri_ovf_out       (ri_ovf_out),
    .chr_a_out        (chr_a_out),
    .chr_d_in         (chr_d_in)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) rd_pend <= rd_issue;

  // Monitor: pop and compare whenever the DUT presents read data
  always @(negedge clk_in) begin : monitor
    logic [7:0] e;
    if (ri_rd_vld_out) begin
      n_checks++;
      if (cq.size() == 0) begin
        n_errors++;
        $display("FAIL ri_rd_unexpected: got %h with no read outstanding", ri_d_out);
      end else begin
        e = cq.pop_front();
        if (ri_d_out !== e) begin
          n_errors++;
          $display("FAIL ri_rd_data: got %h expected %h", ri_d_out, e);
        end
      end
    end
    if (rd_pend) begin
      n_checks++;
      if (rq.size() == 0) begin
        n_errors++;
        $display("FAIL rd_unexpected: got %h with no fetch outstanding", rd_d_out);
      end else begin
        e = rq.pop_front();
        if (rd_d_out !== e) begin
          n_errors++;
          $display("FAIL rd_data: got %h expected %h", rd_d_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!ri_busy_out) break;
      tick();
    end
    chk("busy_clear", 16'(ri_busy_out), 16'h0);
  endtask

  task automatic cpu_wr(input logic [13:0] a, input logic [7:0] d);
    ri_req_in = 1'b1;
    ri_we_in  = 1'b1;
    ri_a_in   = a;
    ri_d_in   = d;
    tick();
    ri_req_in = 1'b0;
    ri_we_in  = 1'b0;
  endtask

  task automatic cpu_rd(input logic [13:0] a, input logic [7:0] exp);
    cq.push_back(exp);
    ri_req_in = 1'b1;
    ri_we_in  = 1'b0;
    ri_a_in   = a;
    tick();
    ri_req_in = 1'b0;
  endtask

  task automatic render_rd(input logic [13:0] a, input logic [7:0] cd, input logic [7:0] exp);
    rd_a_in  = a;
    chr_d_in = cd;
    rd_issue = 1'b1;
    rq.push_back(exp);
    tick();
    rd_issue = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_d"},   16'(rd_d_out),      16'h0);
    chk({tag, "_ri_d"},   16'(ri_d_out),      16'h0);
    chk({tag, "_vld"},    16'(ri_rd_vld_out), 16'h0);
    chk({tag, "_busy"},   16'(ri_busy_out),   16'h0);
    chk({tag, "_ovf"},    16'(ri_ovf_out),    16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset
    #2 rst_in = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (2) @(posedge clk_in);
    #3 rst_in = 1'b1;
    tick();

    // Vertical mirroring
    mirror_v_in = 1'b1;
    cpu_wr(14'h2405, 8'h3C); wait_idle();
    cpu_wr(14'h2005, 8'hA5); wait_idle();
    cpu_rd(14'h2805, 8'hA5); wait_idle();
    cpu_rd(14'h3005, 8'hA5); wait_idle();
    cpu_rd(14'h2405, 8'h3C); wait_idle();

    // Horizontal mirroring; earlier data stays where it was stored
    mirror_v_in = 1'b0;
    cpu_wr(14'h2005, 8'hA5); wait_idle();
    cpu_rd(14'h2405, 8'hA5); wait_idle();
    cpu_rd(14'h2805, 8'h3C); wait_idle();

    // Write then read on consecutive slots, second request accepted at slot edge
    cpu_wr(14'h2222, 8'h5C);
    cpu_rd(14'h2222, 8'h5C);
    wait_idle();
    chk("b2b_no_ovf", 16'(ri_ovf_out), 16'h0);

    // Palette aliasing
    cpu_wr(14'h3F11, 8'h15); wait_idle();
    cpu_wr(14'h3F10, 8'hFF); wait_idle();
    cpu_rd(14'h3F00, 8'h3F); wait_idle();
    cpu_wr(14'h3F01, 8'h2C); wait_idle();
    cpu_rd(14'h3F11, 8'h15); wait_idle();
    cpu_rd(14'h3F01, 8'h2C); wait_idle();
    cpu_wr(14'h3F1C, 8'h2A); wait_idle();
    cpu_rd(14'h3F0C, 8'h2A); wait_idle();

    // Render priority with a CPU read held off for 20 cycles
    cpu_wr(14'h2000, 8'h77); wait_idle();
    render_active_in = 1'b1;
    cpu_rd(14'h2000, 8'h77);
    for (int i = 0; i < 20; i++) begin
      render_rd(14'h0100 + 14'(i), 8'h40 + 8'(i), 8'h40 + 8'(i));
      chk("prio_busy", 16'(ri_busy_out), 16'h1);
    end
    render_active_in = 1'b0;
    tick();
    chk("prio_busy_drop", 16'(ri_busy_out), 16'h0);
    chk("prio_vld", 16'(ri_rd_vld_out), 16'h1);
    chk("prio_rd_hold", 16'(rd_d_out), 16'h53);
    tick();
    chk("prio_vld_single", 16'(ri_rd_vld_out), 16'h0);

    // Overflow: second request dropped while the renderer owns the port
    render_active_in = 1'b1;
    cpu_wr(14'h2100, 8'h11);
    cpu_wr(14'h2100, 8'h22);
    chk("ovf_set", 16'(ri_ovf_out), 16'h1);
    chk("ovf_busy", 16'(ri_busy_out), 16'h1);
    render_active_in = 1'b0;
    wait_idle();
    cpu_rd(14'h2100, 8'h11); wait_idle();

    // CHR forwarding; CPU write to CHR has no effect on the nametable
    render_active_in = 1'b1;
    rd_a_in  = 14'h1234;
    chr_d_in = 8'h5A;
    #1 chk("chr_addr", 16'(chr_a_out), 16'h1234);
    rq.push_back(8'h5A);
    rd_issue = 1'b1;
    tick();
    rd_issue = 1'b0;
    render_active_in = 1'b0;
    cpu_wr(14'h0100, 8'hEE); wait_idle();
    chr_d_in = 8'h99;
    cpu_rd(14'h0100, 8'h99); wait_idle();
    cpu_rd(14'h2100, 8'h11); wait_idle();
    tick();

    // Asynchronous reset with a write pending
    render_active_in = 1'b1;
    cpu_wr(14'h2100, 8'h55);
    chk("rst_pending_busy", 16'(ri_busy_out), 16'h1);
    #2 rst_in = 1'b0;
    #1 chk_reset_outputs("async_rst");
    render_active_in = 1'b0;
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    tick();
    cpu_rd(14'h2100, 8'h11); wait_idle();

    repeat (3) tick();
    chk("cpu_q_drained", 16'(cq.size()), 16'h0);
    chk("rd_q_drained", 16'(rq.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ppu_vram.md
# ppu_vram

PPU video-memory responder: answers the address/data bus driven by the background fetcher and arbitrates it against CPU register-interface accesses. Owns the 2 KiB nametable RAM (with H/V mirroring), the 32-byte palette RAM with its alias rules, and forwards pattern-table addresses to the external CHR ROM. It sits between the background/sprite fetch logic and the cartridge CHR port, inside the PPU.

## Interface
Parameters:
- NT_AW, 11, nametable RAM address width (2 KiB)
- PAL_AW, 5, palette RAM address width (32 entries)

Ports:
- clk_in  input  1  PPU clock; the only clock.
- rst_in  input  1  reset; asynchronous, active-low.
- render_active_in  input  1  1 = renderer owns the memory port this cycle.
- mirror_v_in  input  1  1 = vertical mirroring, 0 = horizontal.
- rd_a_in  input  14  renderer fetch address.
- rd_d_out  output  8  renderer read data, registered.
- ri_req_in  input  1  CPU access request, one-cycle pulse.
- ri_we_in  input  1  1 = write, 0 = read; qualified by ri_req_in.
- ri_a_in  input  14  CPU access address; qualified by ri_req_in.
- ri_d_in  input  8  CPU write data; qualified by ri_req_in.
- ri_d_out  output  8  CPU read data.
- ri_rd_vld_out  output  1  one-cycle pulse when ri_d_out carries new read data.
- ri_busy_out  output  1  1 = a CPU request is pending.
- ri_ovf_out  output  1  sticky flag: a request was dropped. Cleared only by reset.
- chr_a_out  output  13  CHR ROM address; combinational.
- chr_d_in  input  8  CHR ROM data; valid in the same cycle.

## Operation
- Address decode on the shared port address A[13:0] (A is rd_a_in, or the pending CPU address during a CPU slot):
  - A[13]=0: CHR. chr_a_out = A[12:0]. Read returns chr_d_in. Writes are ignored (ROM).
  - 0x2000–0x3EFF: nametable. RAM index = {mirror_v_in ? A[10] : A[11], A[9:0]}. 0x3000–0x3EFF mirrors 0x2000–0x2EFF.
  - 0x3F00–0x3FFF: palette. Index = A[4:0], except 0x10/0x14/0x18/0x1C, which alias to 0x00/0x04/0x08/0x0C. Writes store d[5:0]. Reads return {2'b00, pal[5:0]}.
- Pending buffer: one entry holding {we, a, d}.
  - ri_req_in with buffer empty: capture the request and set ri_busy_out.
  - ri_req_in with buffer full: drop the request, set ri_ovf_out, leave the buffer unchanged.
- Arbiter, two states:
  - RENDER: taken when render_active_in=1 or the buffer is empty. Port serves rd_a_in.
  - CPU_SLOT: taken when render_active_in=0 and the buffer is full. Port serves the buffered request.
  - In CPU_SLOT: a write commits at the clock edge; a read loads ri_d_out and pulses ri_rd_vld_out; the buffer is cleared.
- A request arriving at the same edge a slot completes is accepted, because the buffer is free after that edge.
- rd_d_out holds its previous value during a CPU_SLOT cycle. chr_a_out follows the slot address.
- The renderer and CPU never access memory in the same cycle; the renderer always wins while render_active_in=1.

## Timing
- Reset (asynchronous, while rst_in=0):
  - rd_d_out=0x00, ri_d_out=0x00, ri_rd_vld_out=0, ri_busy_out=0, ri_ovf_out=0.
  - Buffer emptied; a pending write is discarded and not committed.
  - RAM contents are not initialised.
- Renderer read: rd_a_in presented in cycle N; rd_d_out is valid after edge N+1 (latency 1). Back-to-back reads every cycle are supported.
- CPU access: ri_req_in sampled at edge E sets ri_busy_out after E. The first edge E' > E with render_active_in=0 executes the slot. After E', ri_busy_out=0 and, for a read, ri_rd_vld_out=1 for exactly one cycle. Minimum latency is E' = E+1.
- Write then read to the same address on consecutive slots returns the new data.
- A change of mirror_v_in takes effect on the next access; stored data is not relocated.

## Test plan
- Mirroring: mirror_v_in=1, CPU write 0x2005←0xA5; reads of 0x2805 and 0x3005 return 0xA5, and 0x2405 is unaffected. Repeat with mirror_v_in=0: 0x2405 returns 0xA5.
- Palette alias: write 0x3F10←0xFF; read 0x3F00 returns 0x3F. Write 0x3F01←0x2C; read 0x3F11 returns its own value, not 0x2C.
- Render priority: render_active_in=1 for 20 cycles while a CPU read of 0x2000 is pending → ri_busy_out stays 1 and rd_d_out tracks rd_a_in with 1-cycle latency. One cycle after render_active_in drops, ri_rd_vld_out pulses with the stored byte.
- Overflow: two ri_req_in pulses while render_active_in=1 → first request retained, ri_ovf_out=1, only the first write lands after release.
- CHR: rd_a_in=0x1234, chr_d_in=0x5A → chr_a_out=0x1234 and rd_d_out=0x5A next cycle. CPU write to 0x0100 → no side effect.
- Async reset mid-operation: assert rst_in=0 with a write pending → all outputs return to reset values immediately. After release, reading the target address shows the old data.
